// File: rtl/mp_mem_if.sv
// Line-handshake bundle between NPORT cache-line masters and mp_mem_model.
// err_o exists only when MP_MEM_OOR_ERR_EN is defined.
interface mp_mem_if #(
  parameter int NPORT     = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 256
);
  logic [NPORT-1:0]           strobe_i;
  logic [NPORT-1:0]           rw_i;
  logic [NPORT*ADDR_W-1:0]    addr_i;
  logic [NPORT*LINE_BITS-1:0] wdata_i;
  logic [NPORT*LINE_BITS-1:0] rdata_o;
  logic [NPORT-1:0]           done_o;
`ifdef MP_MEM_OOR_ERR_EN
  logic [NPORT-1:0]           err_o;
`endif

  modport master (
    output strobe_i, rw_i, addr_i, wdata_i,
    input  rdata_o, done_o
`ifdef MP_MEM_OOR_ERR_EN
    , err_o
`endif
  );

  modport slave (
    input  strobe_i, rw_i, addr_i, wdata_i,
    output rdata_o, done_o
`ifdef MP_MEM_OOR_ERR_EN
    , err_o
`endif
  );
endinterface

// File: rtl/mp_mem_model.sv
// Multi-port mock main memory: round-robin arbitration, programmable latency, one access in flight.
// Define MP_MEM_OOR_ERR_EN to flag out-of-range accesses on err_o instead of wrapping the index.
module mp_mem_model #(
  parameter int                NPORT       = 2,
  parameter int                ADDR_W      = 32,
  parameter int                LINE_BITS   = 256,
  parameter int                DEPTH_LINES = 16384,
  parameter int                LATENCY     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  mp_mem_if.slave  bus
);
  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                     state_q;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [PTR_W-1:0]           grant_q, grant_d;
  logic [7:0]                 cnt_q;
  logic                       rw_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [LINE_BITS-1:0]       wdata_q;
  logic [NPORT-1:0]           done_q;
  logic [NPORT*LINE_BITS-1:0] rdata_q;
  logic [LINE_BITS-1:0]       mem_q [DEPTH_LINES];

  logic [ADDR_W-1:0]          idx_full;
  logic [IDX_W-1:0]           idx;
  logic                       in_range;
  logic                       access;
  logic [LINE_BITS-1:0]       rd_line;

  // Lowest requester at or above the pointer; otherwise the lowest requester overall (cyclic wrap).
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NPORT-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] sel;
    sel = '0;
    for (int p = NPORT - 1; p >= 0; p--)
      if (req[p]) sel = PTR_W'(p);
    for (int p = NPORT - 1; p >= 0; p--)
      if (req[p] && (PTR_W'(p) >= ptr)) sel = PTR_W'(p);
    return sel;
  endfunction

  always_comb begin
    grant_d = rr_pick(bus.strobe_i, ptr_q);
    if (NPORT == 1 || int'(grant_d) == NPORT - 1) ptr_d = '0;
    else                                          ptr_d = grant_d + PTR_W'(1);
  end

  // Subtraction wraps modulo 2^ADDR_W, so addresses below the base land far out of range.
  assign idx_full = (addr_q - BASE_ADDR) >> OFF_W;
  assign idx      = idx_full[IDX_W-1:0];
`ifdef MP_MEM_OOR_ERR_EN
  assign in_range = (addr_q >= BASE_ADDR) && ((idx_full >> IDX_W) == '0);
`else
  logic unused_idx_hi;
  assign unused_idx_hi = ^idx_full;
  assign in_range = 1'b1;
`endif

  assign access  = (state_q == BUSY) && (cnt_q == 8'd1);
  assign rd_line = in_range ? mem_q[idx] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i && access && rw_q && in_range)
      mem_q[idx] <= wdata_q;
  end

`ifdef MP_MEM_OOR_ERR_EN
  logic [NPORT-1:0] err_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
`ifdef MP_MEM_OOR_ERR_EN
      err_q   <= '0;
`endif
    end else begin
      done_q <= '0;
`ifdef MP_MEM_OOR_ERR_EN
      err_q  <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (|bus.strobe_i) begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            rw_q    <= bus.rw_i[grant_d];
            addr_q  <= bus.addr_i[grant_d*ADDR_W +: ADDR_W];
            wdata_q <= bus.wdata_i[grant_d*LINE_BITS +: LINE_BITS];
            cnt_q   <= 8'(LATENCY);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_q <= DONE;
            for (int p = 0; p < NPORT; p++) begin
              if (grant_q == PTR_W'(p)) begin
                done_q[p] <= 1'b1;
                if (!rw_q) rdata_q[p*LINE_BITS +: LINE_BITS] <= rd_line;
`ifdef MP_MEM_OOR_ERR_EN
                err_q[p] <= !in_range;
`endif
              end
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.done_o  = done_q;
  assign bus.rdata_o = rdata_q;
`ifdef MP_MEM_OOR_ERR_EN
  assign bus.err_o   = err_q;
`endif
endmodule

// File: tb/tb_mp_mem_model.sv
// Bench for mp_mem_model: a 3-port instance (latency 4, base 0) and a small 2-port instance
// (16 lines, latency 3, base 0x1000) for range handling; expectations queued in a scoreboard.
module tb_mp_mem_model;
  localparam int LB = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mp_mem_if #(.NPORT(3), .ADDR_W(32), .LINE_BITS(LB)) ifa ();
  mp_mem_if #(.NPORT(2), .ADDR_W(32), .LINE_BITS(LB)) ifb ();

  mp_mem_model #(.NPORT(3), .ADDR_W(32), .LINE_BITS(LB), .DEPTH_LINES(16384),
                 .LATENCY(4), .BASE_ADDR(32'h0000_0000))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));

  mp_mem_model #(.NPORT(2), .ADDR_W(32), .LINE_BITS(LB), .DEPTH_LINES(16),
                 .LATENCY(3), .BASE_ADDR(32'h0000_1000))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  typedef struct {
    int            port;
    logic [LB-1:0] data;
    logic          err;
  } exp_t;
  exp_t sb[$];

  int            gport [8];
  int            gcyc  [8];
  logic [LB-1:0] gdata [8];

  logic [LB-1:0] pat_a5, pat_old;

  // One access on instance A; reports latency, read line, stray done pulses and pulse overrun.
  task automatic a_access(input int p, input logic rw, input logic [31:0] addr,
                          input logic [LB-1:0] wd, output int lat, output logic [LB-1:0] rd,
                          output int oth, output int ext, output logic e);
    int  start;
    bit  seen;
    @(posedge clk); #1;
    ifa.strobe_i[p] = 1'b1;
    ifa.rw_i[p] = rw;
    ifa.addr_i[p*32 +: 32] = addr;
    ifa.wdata_i[p*LB +: LB] = wd;
    start = cyc; lat = -1; oth = 0; seen = 1'b0; rd = '0; e = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      for (int q = 0; q < 3; q++) if (q != p && ifa.done_o[q]) oth++;
      if (ifa.done_o[p]) begin
        seen = 1'b1;
        lat  = cyc - start;
        rd   = ifa.rdata_o[p*LB +: LB];
`ifdef MP_MEM_OOR_ERR_EN
        e    = ifa.err_o[p];
`endif
      end
    end
    @(posedge clk); #1;
    ifa.strobe_i[p] = 1'b0;
    @(negedge clk);
    ext = int'(ifa.done_o[p]);
  endtask

  task automatic b_access(input int p, input logic rw, input logic [31:0] addr,
                          input logic [LB-1:0] wd, output int lat, output logic [LB-1:0] rd,
                          output logic e);
    int  start;
    bit  seen;
    @(posedge clk); #1;
    ifb.strobe_i[p] = 1'b1;
    ifb.rw_i[p] = rw;
    ifb.addr_i[p*32 +: 32] = addr;
    ifb.wdata_i[p*LB +: LB] = wd;
    start = cyc; lat = -1; seen = 1'b0; rd = '0; e = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ifb.done_o[p]) begin
        seen = 1'b1;
        lat  = cyc - start;
        rd   = ifb.rdata_o[p*LB +: LB];
`ifdef MP_MEM_OOR_ERR_EN
        e    = ifb.err_o[p];
`endif
      end
    end
    @(posedge clk); #1;
    ifb.strobe_i[p] = 1'b0;
    @(negedge clk);
  endtask

  // Concurrent reads of one address on instance A; records grant order, done cycle and data.
  task automatic a_multi(input logic [2:0] mask, input bit reissue, input int n,
                         input logic [31:0] addr);
    int           ng;
    logic [2:0]   drop, raise;
    for (int i = 0; i < 8; i++) begin gport[i] = -1; gcyc[i] = 0; gdata[i] = '0; end
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++) begin
      if (mask[p]) begin
        ifa.strobe_i[p] = 1'b1;
        ifa.rw_i[p] = 1'b0;
        ifa.addr_i[p*32 +: 32] = addr;
      end
    end
    ng = 0; drop = '0; raise = '0;
    for (int c = 0; c < 200 && ng < n; c++) begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        if (ifa.done_o[p] && ng < 8) begin
          gport[ng] = p; gcyc[ng] = cyc; gdata[ng] = ifa.rdata_o[p*LB +: LB];
          ng++;
          drop[p] = 1'b1;
        end
      end
      @(posedge clk); #1;
      for (int p = 0; p < 3; p++) if (raise[p]) ifa.strobe_i[p] = 1'b1;
      raise = '0;
      for (int p = 0; p < 3; p++) begin
        if (drop[p]) begin
          ifa.strobe_i[p] = 1'b0;
          if (reissue) raise[p] = 1'b1;
        end
      end
      drop = '0;
    end
    ifa.strobe_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ifa.done_o !== 3'b000) begin
      failures++; $display("FAIL reset_done_a got=%b exp=000", ifa.done_o);
    end
    checks++;
    if (ifa.rdata_o !== '0) begin
      failures++; $display("FAIL reset_rdata_a got=%0h exp=0", ifa.rdata_o);
    end
    checks++;
    if (ifb.done_o !== 2'b00) begin
      failures++; $display("FAIL reset_done_b got=%b exp=00", ifb.done_o);
    end
    checks++;
    if (ifb.rdata_o !== '0) begin
      failures++; $display("FAIL reset_rdata_b got=%0h exp=0", ifb.rdata_o);
    end
`ifdef MP_MEM_OOR_ERR_EN
    checks++;
    if (ifa.err_o !== 3'b000 || ifb.err_o !== 2'b00) begin
      failures++; $display("FAIL reset_err got=%b/%b exp=0", ifa.err_o, ifb.err_o);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int            lat, oth, ext;
    logic [LB-1:0] rd;
    logic          e;
    exp_t          x;
    a_access(0, 1'b1, 32'h60, pat_a5, lat, rd, oth, ext, e);
    checks++;
    if (lat != 5) begin failures++; $display("FAIL preload_latency got=%0d exp=5", lat); end
    sb.push_back(exp_t'{0, pat_a5, 1'b0});
    a_access(0, 1'b0, 32'h60, '0, lat, rd, oth, ext, e);
    x = sb.pop_front();
    checks++;
    if (lat != 5) begin failures++; $display("FAIL read_latency got=%0d exp=5", lat); end
    checks++;
    if (rd !== x.data) begin failures++; $display("FAIL read_data got=%0h exp=%0h", rd, x.data); end
    checks++;
    if (oth != 0) begin failures++; $display("FAIL read_other_done got=%0d exp=0", oth); end
    checks++;
    if (ext != 0) begin failures++; $display("FAIL done_width got=%0d exp=0", ext); end
    checks++;
    if (e !== x.err) begin failures++; $display("FAIL read_err got=%b exp=%b", e, x.err); end
  endtask

  task automatic test_write_read();
    int            lat, oth, ext;
    logic [LB-1:0] rd, db;
    logic          e;
    exp_t          x;
    db = {8{32'hDEADBEEF}};
    a_access(1, 1'b1, 32'h1000, db, lat, rd, oth, ext, e);
    checks++;
    if (lat != 5) begin failures++; $display("FAIL write_latency got=%0d exp=5", lat); end
    checks++;
    if (ifa.rdata_o[LB +: LB] !== '0) begin
      failures++; $display("FAIL write_keeps_rdata got=%0h exp=0", ifa.rdata_o[LB +: LB]);
    end
    sb.push_back(exp_t'{1, db, 1'b0});
    a_access(1, 1'b0, 32'h101C, '0, lat, rd, oth, ext, e);
    x = sb.pop_front();
    checks++;
    if (rd !== x.data) begin failures++; $display("FAIL offset_read got=%0h exp=%0h", rd, x.data); end
    checks++;
    if (ifa.rdata_o[0 +: LB] !== pat_a5) begin
      failures++; $display("FAIL port0_rdata_hold got=%0h exp=%0h", ifa.rdata_o[0 +: LB], pat_a5);
    end
    checks++;
    if (oth != 0) begin failures++; $display("FAIL wr_other_done got=%0d exp=0", oth); end
  endtask

  task automatic test_busy_reset();
    int            lat, oth, ext, nd;
    logic [LB-1:0] rd, nw;
    logic          e;
    exp_t          x;
    nw = {8{32'h1234_5678}};
    a_access(0, 1'b1, 32'hA0, pat_old, lat, rd, oth, ext, e);
    checks++;
    if (lat != 5) begin failures++; $display("FAIL old_write_latency got=%0d exp=5", lat); end
    @(posedge clk); #1;
    ifa.strobe_i[2] = 1'b1;
    ifa.rw_i[2] = 1'b1;
    ifa.addr_i[2*32 +: 32] = 32'hA0;
    ifa.wdata_i[2*LB +: LB] = nw;
    // cycles t+1..t+3 are BUSY with cnt 4,3,2; reset is sampled while cnt is 2
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    ifa.strobe_i[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifa.done_o !== 3'b000) nd++;
    end
    checks++;
    if (nd != 0) begin failures++; $display("FAIL busy_reset_done got=%0d exp=0", nd); end
    checks++;
    if (ifa.rdata_o !== '0) begin
      failures++; $display("FAIL busy_reset_rdata got=%0h exp=0", ifa.rdata_o);
    end
    sb.push_back(exp_t'{0, pat_old, 1'b0});
    sb.push_back(exp_t'{2, pat_old, 1'b0});
    a_multi(3'b101, 1'b0, 2, 32'hA0);
    for (int i = 0; i < 2; i++) begin
      x = sb.pop_front();
      checks++;
      if (gport[i] != x.port) begin
        failures++; $display("FAIL post_reset_grant%0d got=%0d exp=%0d", i, gport[i], x.port);
      end
      checks++;
      if (gdata[i] !== x.data) begin
        failures++; $display("FAIL line5_kept%0d got=%0h exp=%0h", i, gdata[i], x.data);
      end
    end
  endtask

  task automatic test_contention();
    exp_t x;
    for (int i = 0; i < 6; i++) sb.push_back(exp_t'{i % 3, pat_old, 1'b0});
    a_multi(3'b111, 1'b1, 6, 32'hA0);
    for (int i = 0; i < 6; i++) begin
      x = sb.pop_front();
      checks++;
      if (gport[i] != x.port) begin
        failures++; $display("FAIL rr_order%0d got=%0d exp=%0d", i, gport[i], x.port);
      end
      checks++;
      if (gdata[i] !== x.data) begin
        failures++; $display("FAIL rr_data%0d got=%0h exp=%0h", i, gdata[i], x.data);
      end
      if (i > 0) begin
        checks++;
        if (gcyc[i] - gcyc[i-1] != 6) begin
          failures++; $display("FAIL rr_spacing%0d got=%0d exp=6", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_oor();
    int            lat;
    logic [LB-1:0] rd, p0, p15, px;
    logic          e;
    exp_t          x;
    p0  = {8{32'h0000_AAAA}};
    p15 = {8{32'hFFFF_0015}};
    px  = {8{32'h7777_7777}};
    b_access(0, 1'b1, 32'h1000, p0, lat, rd, e);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL b_write_latency got=%0d exp=4", lat); end
    b_access(1, 1'b1, 32'h11E0, p15, lat, rd, e);
`ifdef MP_MEM_OOR_ERR_EN
    sb.push_back(exp_t'{0, '0, 1'b1});
`else
    sb.push_back(exp_t'{0, p0, 1'b0});
`endif
    b_access(0, 1'b0, 32'h1200, '0, lat, rd, e);
    x = sb.pop_front();
    checks++;
    if (lat != 4) begin failures++; $display("FAIL oor_latency got=%0d exp=4", lat); end
    checks++;
    if (rd !== x.data) begin failures++; $display("FAIL oor_read got=%0h exp=%0h", rd, x.data); end
    checks++;
    if (e !== x.err) begin failures++; $display("FAIL oor_err got=%b exp=%b", e, x.err); end
    b_access(1, 1'b1, 32'h1200, px, lat, rd, e);
`ifdef MP_MEM_OOR_ERR_EN
    checks++;
    if (e !== 1'b1) begin failures++; $display("FAIL oor_write_err got=%b exp=1", e); end
    sb.push_back(exp_t'{0, p0, 1'b0});
`else
    sb.push_back(exp_t'{0, px, 1'b0});
`endif
    b_access(0, 1'b0, 32'h1000, '0, lat, rd, e);
    x = sb.pop_front();
    checks++;
    if (rd !== x.data) begin failures++; $display("FAIL line0_after_oor_write got=%0h exp=%0h", rd, x.data); end
`ifdef MP_MEM_OOR_ERR_EN
    sb.push_back(exp_t'{1, '0, 1'b1});
`else
    sb.push_back(exp_t'{1, p15, 1'b0});
`endif
    b_access(1, 1'b0, 32'h0FE0, '0, lat, rd, e);
    x = sb.pop_front();
    checks++;
    if (rd !== x.data) begin failures++; $display("FAIL below_base_read got=%0h exp=%0h", rd, x.data); end
    checks++;
    if (e !== x.err) begin failures++; $display("FAIL below_base_err got=%b exp=%b", e, x.err); end
    sb.push_back(exp_t'{0, p15, 1'b0});
    b_access(0, 1'b0, 32'h11E0, '0, lat, rd, e);
    x = sb.pop_front();
    checks++;
    if (rd !== x.data) begin failures++; $display("FAIL last_line_read got=%0h exp=%0h", rd, x.data); end
    checks++;
    if (e !== x.err) begin failures++; $display("FAIL last_line_err got=%b exp=%b", e, x.err); end
  endtask

  initial begin
    ifa.strobe_i = '0; ifa.rw_i = '0; ifa.addr_i = '0; ifa.wdata_i = '0;
    ifb.strobe_i = '0; ifb.rw_i = '0; ifb.addr_i = '0; ifb.wdata_i = '0;
    pat_a5  = {32{8'hA5}};
    pat_old = {8{32'h0BAD_F00D}};
    test_reset();
    test_single_read();
    test_write_read();
    test_busy_reset();
    test_contention();
    test_oor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
